// File: rtl/ysyx_22040895_mdu_ctrl_if.sv
// Request/response bundle between decode/execute and the M-extension sequencer.
interface ysyx_22040895_mdu_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            valid_i;
  logic            ready_o;
  logic [3:0]      mdu_op_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            busy_o;

  modport slave (
    input  valid_i, mdu_op_i, op1_i, op2_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );

  modport master (
    output valid_i, mdu_op_i, op1_i, op2_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/ysyx_22040895_mdu_ctrl.sv
// Iterative RV64M sequencer: shift-add multiplier and restoring divider, one bit per cycle.
module ysyx_22040895_mdu_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22040895_mdu_ctrl_if.slave bus
);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [6:0]      cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   prod_q, prod_d, mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d, dvsr_q, dvsr_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  logic            is_w, is_div, is_rem, reserved, s1, s2, na, nb, div_zero, div_ovf;
  logic [XLEN-1:0] a, b, mag_a, mag_b, min_val;

  // Decode the incoming request and turn operands into magnitudes plus sign flags
  always_comb begin
    is_w     = bus.mdu_op_i[3];
    is_div   = bus.mdu_op_i[2];
    is_rem   = bus.mdu_op_i[2] & bus.mdu_op_i[1];
    reserved = bus.mdu_op_i inside {4'd9, 4'd10, 4'd11};
    if (is_div) begin
      s1 = ~bus.mdu_op_i[0];
      s2 = ~bus.mdu_op_i[0];
    end else begin
      // MUL/MULH signed*signed, MULHSU signed*unsigned, MULHU unsigned*unsigned
      s1 = (bus.mdu_op_i[1:0] != 2'd3);
      s2 = ~bus.mdu_op_i[1];
    end
    a = is_w ? {{(XLEN-32){s1 & bus.op1_i[31]}}, bus.op1_i[31:0]} : bus.op1_i;
    b = is_w ? {{(XLEN-32){s2 & bus.op2_i[31]}}, bus.op2_i[31:0]} : bus.op2_i;
    na       = s1 & a[XLEN-1];
    nb       = s2 & b[XLEN-1];
    mag_a    = na ? -a : a;
    mag_b    = nb ? -b : b;
    min_val  = is_w ? {{(XLEN-32){1'b1}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div & (b == '0);
    div_ovf  = is_div & s1 & (a == min_val) & (b == '1);
  end

  logic [PW-1:0]   prod_n, prod_c;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] quo_n, rem_n, quo_c, rem_c, fin;

  // One multiply/divide step, plus the sign-corrected result of that step
  always_comb begin
    prod_n = mplier_q[0] ? prod_q + mcand_q : prod_q;
    rem_sh = {rem_q, quo_q[XLEN-1]};
    if (rem_sh >= {1'b0, dvsr_q}) begin
      rem_n = rem_sh[XLEN-1:0] - dvsr_q;
      quo_n = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[XLEN-1:0];
      quo_n = {quo_q[XLEN-2:0], 1'b0};
    end
    // Negate the full product before picking a half so MULH* borrow correctly
    prod_c = neg_q ? -prod_n : prod_n;
    quo_c  = neg_q ? -quo_n : quo_n;
    rem_c  = neg_q ? -rem_n : rem_n;
    if (!op_q[2]) begin
      fin = (op_q[1:0] == 2'd0) ? prod_c[XLEN-1:0] : prod_c[PW-1:XLEN];
    end else begin
      fin = op_q[1] ? rem_c : quo_c;
    end
    if (op_q[3]) begin
      fin = sext32(fin);
    end
  end

  // Sequencer next state: accept, iterate, hold result until taken; flush wins
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    dvsr_d   = dvsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.valid_i) begin
          op_d     = bus.mdu_op_i;
          neg_d    = is_rem ? na : (na ^ nb);
          prod_d   = '0;
          mcand_d  = {{XLEN{1'b0}}, mag_a};
          mplier_d = mag_b;
          dvsr_d   = mag_b;
          rem_d    = '0;
          // W divides start from bit 31, so park the dividend in the top half
          quo_d    = is_w ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
          if (reserved) begin
            result_d = '0;
            state_d  = StDone;
          end else if (div_zero) begin
            result_d = is_rem ? (is_w ? sext32(bus.op1_i) : bus.op1_i) : '1;
            state_d  = StDone;
          end else if (div_ovf) begin
            result_d = is_rem ? '0 : a;
            state_d  = StDone;
          end else begin
            cnt_d   = is_w ? 7'd32 : 7'd64;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        prod_d   = prod_n;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        quo_d    = quo_n;
        rem_d    = rem_n;
        cnt_d    = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          result_d = fin;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (bus.ready_i) begin
          result_d = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.flush_i) begin
      state_d  = StIdle;
      result_d = '0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      dvsr_q   <= dvsr_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign bus.ready_o  = (state_q == StIdle);
  assign bus.busy_o   = (state_q != StIdle);
  assign bus.valid_o  = (state_q == StDone);
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_ysyx_22040895_mdu_ctrl.sv
// Randomized bench for the M-extension sequencer against a transaction-level reference.
module tb_ysyx_22040895_mdu_ctrl;
  localparam logic [63:0] Min64 = 64'h8000_0000_0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22040895_mdu_ctrl_if #(.XLEN(64)) bus ();

  ysyx_22040895_mdu_ctrl #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          check_en = 0;
  bit          in_flight = 0;
  int          done_at = 0;
  logic [63:0] exp_res = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Architectural result of one RV64M operation
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0]       p;
    logic signed [63:0] sa, sb, sr;
    logic signed [31:0] wa, wb, wr;
    logic [31:0]        ua, ub, ur;
    logic [63:0]        r;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    r = '0;
    case (op)
      4'd0: r = a * b;
      4'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      4'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
      4'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
      4'd4: begin
        if (b == 0) r = '1;
        else if (a == Min64 && b == '1) r = a;
        else begin sr = sa / sb; r = sr; end
      end
      4'd5: if (b == 0) r = '1; else r = a / b;
      4'd6: begin
        if (b == 0) r = a;
        else if (a == Min64 && b == '1) r = '0;
        else begin sr = sa % sb; r = sr; end
      end
      4'd7: if (b == 0) r = a; else r = a % b;
      4'd8: begin ur = ua * ub; r = sx(ur); end
      4'd12: begin
        if (ub == 0) r = '1;
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = sx(ua);
        else begin wr = wa / wb; r = sx(wr); end
      end
      4'd13: begin
        if (ub == 0) r = '1;
        else begin ur = ua / ub; r = sx(ur); end
      end
      4'd14: begin
        if (ub == 0) r = sx(ua);
        else if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = '0;
        else begin wr = wa % wb; r = sx(wr); end
      end
      4'd15: begin
        if (ub == 0) r = sx(ua);
        else begin ur = ua % ub; r = sx(ur); end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Operations that complete without iterating
  function automatic bit is_special(input logic [3:0] op, input logic [63:0] a,
                                    input logic [63:0] b);
    if (op inside {4'd9, 4'd10, 4'd11}) return 1'b1;
    if (op inside {4'd4, 4'd5, 4'd6, 4'd7})
      return (b == 0) || (op inside {4'd4, 4'd6} && a == Min64 && b == '1);
    if (op inside {4'd12, 4'd13, 4'd14, 4'd15})
      return (b[31:0] == 0) ||
             (op inside {4'd12, 4'd14} && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return 1'b0;
  endfunction

  // Cycles from the request-presenting cycle to the first cycle valid_o is seen
  function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a,
                                 input logic [63:0] b);
    if (is_special(op, a, b)) return 1;
    return op[3] ? 33 : 65;
  endfunction

  // Transaction-level reference: one result in flight, ready at a known edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    check_en = 1'b1;
    if (rst || bus.flush_i) begin
      in_flight = 1'b0;
    end else if (!in_flight) begin
      if (bus.valid_i) begin
        in_flight = 1'b1;
        exp_res   = ref_result(bus.mdu_op_i, bus.op1_i, bus.op2_i);
        done_at   = is_special(bus.mdu_op_i, bus.op1_i, bus.op2_i) ? cyc :
                    cyc + (bus.mdu_op_i[3] ? 32 : 64);
      end
    end else if (cyc > done_at && bus.ready_i) begin
      in_flight = 1'b0;
    end
  end

  // Every-cycle comparison of all outputs against the reference
  always @(negedge clk) begin
    if (check_en) begin
      bit ev;
      ev = in_flight && (cyc >= done_at);
      chk("ready_o", 64'(bus.ready_o), 64'(!in_flight));
      chk("busy_o", 64'(bus.busy_o), 64'(in_flight));
      chk("valid_o", 64'(bus.valid_o), 64'(ev));
      chk("result_o", bus.result_o, ev ? exp_res : 64'd0);
    end
  end

  task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int hold, output int lat, output logic [63:0] res);
    int t;
    bit got;
    lat = -1;
    res = '0;
    got = 1'b0;
    for (int i = 0; i < 200 && !bus.ready_o; i++) @(negedge clk);
    chk("ready_wait", 64'(bus.ready_o), 64'd1);
    if (!bus.ready_o) return;
    bus.valid_i  = 1'b1;
    bus.mdu_op_i = op;
    bus.op1_i    = a;
    bus.op2_i    = b;
    t = cyc;
    @(negedge clk);
    bus.valid_i  = 1'b0;
    bus.mdu_op_i = 4'($urandom);
    bus.op1_i    = {$urandom, $urandom};
    bus.op2_i    = {$urandom, $urandom};
    for (int i = 0; i < 200; i++) begin
      if (bus.valid_o) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("valid_wait", 64'(got), 64'd1);
    if (!got) return;
    lat = cyc - t;
    res = bus.result_o;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.valid_o), 64'd1);
      chk("hold_ready", 64'(bus.ready_o), 64'd0);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    chk("ready_after", 64'(bus.ready_o), 64'd1);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return Min64;
      3: return 64'($urandom_range(0, 20));
      4: return {32'hFFFF_FFFF, $urandom};
      5: return 64'h0000_0000_8000_0000;
      6: return 64'h1234_5678_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int          lat;
    logic [63:0] res, a, b;
    logic [3:0]  op;
    bus.valid_i  = 1'b0;
    bus.mdu_op_i = '0;
    bus.op1_i    = '0;
    bus.op2_i    = '0;
    bus.flush_i  = 1'b0;
    bus.ready_i  = 1'b0;

    // Pin the reference against hand-computed values
    chk("ref_mul", ref_result(4'd0, 64'd7, -64'sd3), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("ref_mulhu", ref_result(4'd3, '1, 64'd2), 64'd1);
    chk("ref_mulhsu", ref_result(4'd2, '1, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ref_div", ref_result(4'd4, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref_rem", ref_result(4'd6, -64'sd7, 64'd2), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ref_divw", ref_result(4'd12, 64'h0000_0000_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("ref_divu0", ref_result(4'd5, 64'd5, 64'd0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ref_rem0", ref_result(4'd6, 64'd5, 64'd0), 64'd5);
    chk("ref_divovf", ref_result(4'd4, Min64, '1), Min64);
    chk("ref_mulw", ref_result(4'd8, 64'h1_0000, 64'h1_0000), 64'd0);
    chk("ref_remwovf", ref_result(4'd14, 64'h8000_0000, '1), 64'd0);
    chk("ref_divuw", ref_result(4'd13, 64'hFFFF_FFFE, 64'd1), 64'hFFFF_FFFF_FFFF_FFFE);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    do_op(4'd0, 64'd7, -64'sd3, 0, lat, res);
    chk("mul_lat", 64'(lat), 64'd65);
    chk("mul_res", res, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op(4'd3, '1, 64'd2, 0, lat, res);
    chk("mulhu_res", res, 64'd1);
    do_op(4'd4, -64'sd7, 64'd2, 0, lat, res);
    chk("div_res", res, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(4'd6, -64'sd7, 64'd2, 0, lat, res);
    chk("rem_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(4'd12, 64'h0000_0000_FFFF_FFF9, 64'd2, 0, lat, res);
    chk("divw_lat", 64'(lat), 64'd33);
    chk("divw_res", res, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op(4'd5, 64'd5, 64'd0, 0, lat, res);
    chk("divu0_lat", 64'(lat), 64'd1);
    chk("divu0_res", res, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(4'd6, 64'd5, 64'd0, 0, lat, res);
    chk("rem0_lat", 64'(lat), 64'd1);
    chk("rem0_res", res, 64'd5);
    do_op(4'd4, Min64, '1, 0, lat, res);
    chk("divovf_lat", 64'(lat), 64'd1);
    chk("divovf_res", res, Min64);

    // Back-pressure: result parked for 10 cycles
    do_op(4'd1, -64'sd5, 64'd3, 10, lat, res);
    chk("bp_res", res, 64'hFFFF_FFFF_FFFF_FFFF);

    // Flush in the middle of CALC with a competing request
    bus.valid_i  = 1'b1;
    bus.mdu_op_i = 4'd0;
    bus.op1_i    = 64'd123;
    bus.op2_i    = 64'd456;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (19) @(negedge clk);
    bus.flush_i  = 1'b1;
    bus.valid_i  = 1'b1;
    bus.mdu_op_i = 4'd5;
    bus.op2_i    = 64'd0;
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    chk("flush_ready", 64'(bus.ready_o), 64'd1);
    chk("flush_valid", 64'(bus.valid_o), 64'd0);
    chk("flush_busy", 64'(bus.busy_o), 64'd0);
    repeat (3) @(negedge clk);
    do_op(4'd8, 64'h1_0000, 64'h1_0000, 0, lat, res);
    chk("mulw_res", res, 64'd0);
    chk("mulw_lat", 64'(lat), 64'd33);

    // Reset in the middle of CALC
    bus.valid_i  = 1'b1;
    bus.mdu_op_i = 4'd4;
    bus.op1_i    = 64'd1000;
    bus.op2_i    = 64'd7;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_valid", 64'(bus.valid_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_result", bus.result_o, 64'd0);

    // Random traffic over all opcodes and corner operands
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      do_op(op, a, b, $urandom_range(0, 3), lat, res);
      chk("rand_res", res, ref_result(op, a, b));
      chk("rand_lat", 64'(lat), 64'(exp_lat(op, a, b)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
